// File: rtl/heartbeat_pkg.sv
// -----------------------------------------------------------------------------
// heartbeat_pkg
// Shared types and constants for the heartbeat detector front end.
//   hb_state_t       : beat-qualification FSM state encoding
//   HB_*_CYCLES_24M  : default timing constants for a 24 MHz clk
//   sat_inc8         : 8-bit increment that sticks at 255
// -----------------------------------------------------------------------------
package heartbeat_pkg;

    typedef enum logic [1:0] {
        HB_ARMED    = 2'd0,
        HB_REFRACT  = 2'd1,
        HB_WAIT_LOW = 2'd2
    } hb_state_t;

    // 200 us and 200 ms at 24 MHz
    localparam int unsigned HB_DEBOUNCE_CYCLES_24M   = 4_800;
    localparam int unsigned HB_REFRACTORY_CYCLES_24M = 4_800_000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hb_sync_debounce.sv
// -----------------------------------------------------------------------------
// hb_sync_debounce
// Synchronises the raw sense input, debounces it and flags debounced rising
// edges.
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   sense_in  in   raw asynchronous sense level
//   deb_level out  debounced level
//   deb_rise  out  one-cycle registered pulse after deb_level goes 0->1
// -----------------------------------------------------------------------------
module hb_sync_debounce
    import heartbeat_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = HB_DEBOUNCE_CYCLES_24M,
    parameter int unsigned CNT_W           = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sense_in,
    output logic deb_level,
    output logic deb_rise
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   deb_level_q, deb_level_d;
    logic                   deb_prev_q, deb_prev_d;
    logic                   deb_rise_q, deb_rise_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], sense_in};
        deb_cnt_d   = '0;
        deb_level_d = deb_level_q;
        // deb_cnt only runs while the synchronised input disagrees with the
        // accepted level; any agreement restarts the qualification.
        if (sync_out != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = ~deb_level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_ONE;
            end
        end
        deb_prev_d = deb_level_q;
        deb_rise_d = deb_level_q & ~deb_prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            deb_cnt_q   <= '0;
            deb_level_q <= 1'b0;
            deb_prev_q  <= 1'b0;
            deb_rise_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_level_q <= deb_level_d;
            deb_prev_q  <= deb_prev_d;
            deb_rise_q  <= deb_rise_d;
        end
    end

    assign deb_level = deb_level_q;
    assign deb_rise  = deb_rise_q;

endmodule

// File: rtl/heartbeat_detector.sv
// -----------------------------------------------------------------------------
// heartbeat_detector
// Turns the noisy asynchronous cardiac sense input into a clean one-cycle
// beat pulse for the pacing timer, blanking a refractory window after each
// accepted beat.
//   clk             in   system clock (24 MHz)
//   rst_n           in   asynchronous active-low reset
//   sense_in        in   raw sense signal
//   beat_pulse      out  one-cycle pulse per accepted beat
//   refractory      out  high while the refractory window is running
//   beat_count      out  accepted beats, wraps
//   reject_count    out  debounced edges ignored in refractory, saturates
// Optional (macro HB_RATE_MEASURE_EN):
//   interval_cycles out  cycles between the two most recent beats, saturating
//   interval_valid  out  pulses with beat_pulse from the second beat onward
//
// state       | meaning
// ------------+-------------------------------------------------------------
// HB_ARMED    | waiting for a debounced rising edge to accept as a beat
// HB_REFRACT  | blanking window counting down; rising edges are rejected
// HB_WAIT_LOW | window over but level still high; wait for it to drop
// -----------------------------------------------------------------------------
module heartbeat_detector
    import heartbeat_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = HB_DEBOUNCE_CYCLES_24M,
    parameter int unsigned REFRACTORY_CYCLES = HB_REFRACTORY_CYCLES_24M,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sense_in,
    output logic             beat_pulse,
    output logic             refractory,
    output logic [7:0]       beat_count,
    output logic [7:0]       reject_count
`ifdef HB_RATE_MEASURE_EN
    ,
    output logic [CNT_W-1:0] interval_cycles,
    output logic             interval_valid
`endif
);

    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRACTORY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic deb_level;
    logic deb_rise;

    hb_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .sense_in  (sense_in),
        .deb_level (deb_level),
        .deb_rise  (deb_rise)
    );

    hb_state_t        state_q, state_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             beat_pulse_q, beat_pulse_d;
    logic             refractory_q, refractory_d;
    logic [7:0]       beat_cnt_q, beat_cnt_d;
    logic [7:0]       rej_cnt_q, rej_cnt_d;

    always_comb begin
        state_d      = state_q;
        ref_cnt_d    = ref_cnt_q;
        beat_pulse_d = 1'b0;
        beat_cnt_d   = beat_cnt_q;
        rej_cnt_d    = rej_cnt_q;
        case (state_q)
            HB_ARMED: begin
                if (deb_rise) begin
                    beat_pulse_d = 1'b1;
                    beat_cnt_d   = beat_cnt_q + 8'd1;
                    ref_cnt_d    = REF_LAST;
                    state_d      = HB_REFRACT;
                end
            end
            HB_REFRACT: begin
                // An edge landing on the terminal count is still blanked.
                if (deb_rise) begin
                    rej_cnt_d = sat_inc8(rej_cnt_q);
                end
                if (ref_cnt_q == '0) begin
                    state_d = deb_level ? HB_WAIT_LOW : HB_ARMED;
                end else begin
                    ref_cnt_d = ref_cnt_q - CNT_ONE;
                end
            end
            HB_WAIT_LOW: begin
                if (!deb_level) begin
                    state_d = HB_ARMED;
                end
            end
            default: begin
                state_d = HB_ARMED;
            end
        endcase
        // Registered from the current state, so it trails the beat pulse by
        // one cycle and covers exactly REFRACTORY_CYCLES cycles.
        refractory_d = (state_q == HB_REFRACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HB_ARMED;
            ref_cnt_q    <= '0;
            beat_pulse_q <= 1'b0;
            refractory_q <= 1'b0;
            beat_cnt_q   <= '0;
            rej_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ref_cnt_q    <= ref_cnt_d;
            beat_pulse_q <= beat_pulse_d;
            refractory_q <= refractory_d;
            beat_cnt_q   <= beat_cnt_d;
            rej_cnt_q    <= rej_cnt_d;
        end
    end

    assign beat_pulse   = beat_pulse_q;
    assign refractory   = refractory_q;
    assign beat_count   = beat_cnt_q;
    assign reject_count = rej_cnt_q;

`ifdef HB_RATE_MEASURE_EN
    logic [CNT_W-1:0] int_cnt_q, int_cnt_d;
    logic [CNT_W-1:0] interval_q, interval_d;
    logic             int_valid_q, int_valid_d;
    logic             seen_beat_q, seen_beat_d;

    always_comb begin
        int_cnt_d   = (&int_cnt_q) ? int_cnt_q : int_cnt_q + CNT_ONE;
        interval_d  = interval_q;
        int_valid_d = 1'b0;
        seen_beat_d = seen_beat_q;
        if (beat_pulse_d) begin
            // The cycle of the accepted beat counts as 1 of the new interval.
            int_cnt_d   = CNT_ONE;
            seen_beat_d = 1'b1;
            int_valid_d = seen_beat_q;
            if (seen_beat_q) begin
                interval_d = int_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_cnt_q   <= '0;
            interval_q  <= '0;
            int_valid_q <= 1'b0;
            seen_beat_q <= 1'b0;
        end else begin
            int_cnt_q   <= int_cnt_d;
            interval_q  <= interval_d;
            int_valid_q <= int_valid_d;
            seen_beat_q <= seen_beat_d;
        end
    end

    assign interval_cycles = interval_q;
    assign interval_valid  = int_valid_q;
`endif

endmodule

// File: tb/tb_heartbeat_detector.sv
// -----------------------------------------------------------------------------
// tb_heartbeat_detector
// Directed bench for heartbeat_detector with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// REFRACTORY_CYCLES=20. Cycle r is the period following rising edge r after
// reset release; sense_in set during cycle r-1 is first sampled at edge r.
// Define HB_RATE_MEASURE_EN to also exercise the interval outputs.
// -----------------------------------------------------------------------------
module tb_heartbeat_detector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sense_in;
    logic        beat_pulse;
    logic        refractory;
    logic [7:0]  beat_count;
    logic [7:0]  reject_count;
`ifdef HB_RATE_MEASURE_EN
    logic [31:0] interval_cycles;
    logic        interval_valid;
`endif

    int   n_checks   = 0;
    int   n_errors   = 0;
    int   cyc        = 0;
    int   base       = 0;
    int   pulse_cnt  = 0;
    int   last_pulse = 0;
    int   dbl_cnt    = 0;
    logic prev_pulse = 1'b0;

    heartbeat_detector #(
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (4),
        .REFRACTORY_CYCLES (20),
        .CNT_W             (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sense_in        (sense_in),
        .beat_pulse      (beat_pulse),
        .refractory      (refractory),
        .beat_count      (beat_count),
        .reject_count    (reject_count)
`ifdef HB_RATE_MEASURE_EN
        ,
        .interval_cycles (interval_cycles),
        .interval_valid  (interval_valid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: runs at the falling edge, the checks run 1 ns later.
    always @(negedge clk) begin
        if (rst_n && beat_pulse) begin
            pulse_cnt  = pulse_cnt + 1;
            last_pulse = cyc - base;
            if (prev_pulse) dbl_cnt = dbl_cnt + 1;
        end
        prev_pulse = rst_n && beat_pulse;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_to(input int r);
        while (cyc - base < r) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_at(input int r, input logic v);
        step_to(r);
        sense_in = v;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pulse"}, beat_pulse, 0);
        chk({tag, "_refr"}, refractory, 0);
        chk({tag, "_beats"}, beat_count, 0);
        chk({tag, "_rejects"}, reject_count, 0);
    endtask

    task automatic do_reset();
        sense_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_idle("in_reset");
        repeat (3) @(negedge clk);
        #1;
        rst_n     = 1'b1;
        base      = cyc;
        pulse_cnt = 0;
        step_to(1);
        chk_idle("after_release");
    endtask

    initial begin
        rst_n    = 1'b0;
        sense_in = 1'b0;

        // 1 + 4: clean rise held 30 cycles, then a fresh rise after it drops
        do_reset();
        set_at(9, 1'b1);
        for (int r = 10; r <= 45; r++) begin
            step_to(r);
            chk("t1_pulse", beat_pulse, (r == 17));
            chk("t1_refr", refractory, (r >= 18 && r <= 37));
            chk("t1_beats", beat_count, (r >= 17));
            if (r == 39) sense_in = 1'b0;
        end
        set_at(48, 1'b1);
        step_to(60);
        chk("t4_pulses", pulse_cnt, 2);
        chk("t4_last", last_pulse, 56);
        chk("t4_beats", beat_count, 2);
        chk("t4_rejects", reject_count, 0);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        do_reset();
        set_at(9, 1'b1);
        set_at(12, 1'b0);
        step_to(40);
        chk("t2_glitch_pulses", pulse_cnt, 0);
        chk("t2_glitch_beats", beat_count, 0);
        chk("t2_glitch_refr", refractory, 0);
        set_at(49, 1'b1);
        set_at(53, 1'b0);
        step_to(60);
        chk("t2_min_pulses", pulse_cnt, 1);
        chk("t2_min_last", last_pulse, 57);

        // 3: second edge 10 cycles later is rejected, next clean rise pulses
        do_reset();
        set_at(9, 1'b1);
        set_at(15, 1'b0);
        set_at(19, 1'b1);
        set_at(25, 1'b0);
        step_to(26);
        chk("t3_rej_before", reject_count, 0);
        step_to(27);
        chk("t3_rej_after", reject_count, 1);
        step_to(37);
        chk("t3_refr_last", refractory, 1);
        step_to(38);
        chk("t3_refr_end", refractory, 0);
        chk("t3_pulses", pulse_cnt, 1);
        set_at(39, 1'b1);
        step_to(50);
        chk("t3_rearm_pulses", pulse_cnt, 2);
        chk("t3_rearm_last", last_pulse, 47);
        chk("t3_rearm_beats", beat_count, 2);
        chk("t3_rearm_rejects", reject_count, 1);

        // Edge on the terminal refractory cycle: rejected, then WAIT_LOW
        do_reset();
        set_at(9, 1'b1);
        set_at(15, 1'b0);
        set_at(29, 1'b1);
        step_to(36);
        chk("tc_rej_before", reject_count, 0);
        step_to(37);
        chk("tc_rej_at_tc", reject_count, 1);
        step_to(45);
        chk("tc_pulses", pulse_cnt, 1);
        chk("tc_refr", refractory, 0);
        set_at(45, 1'b0);
        set_at(55, 1'b1);
        step_to(66);
        chk("tc_rearm_pulses", pulse_cnt, 2);
        chk("tc_rearm_last", last_pulse, 63);
        chk("tc_rearm_beats", beat_count, 2);

        // 6: async reset in the middle of refractory
        do_reset();
        set_at(9, 1'b1);
        step_to(25);
        chk("t6_refr_pre", refractory, 1);
        chk("t6_beats_pre", beat_count, 1);
        rst_n = 1'b0;
        #1;
        chk_idle("t6_async");
        do_reset();
        step_to(40);
        chk("t6_post_pulses", pulse_cnt, 0);
        chk_idle("t6_post");

`ifdef HB_RATE_MEASURE_EN
        // 6b: beats 40 cycles apart
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_at(9 + 40 * k, 1'b1);
            set_at(15 + 40 * k, 1'b0);
            step_to(17 + 40 * k);
            chk("rate_pulse", beat_pulse, 1);
            chk("rate_valid", interval_valid, (k > 0));
            chk("rate_cycles", interval_cycles, (k > 0) ? 40 : 0);
            step_to(18 + 40 * k);
            chk("rate_valid_drop", interval_valid, 0);
        end
`endif

        // 5: 260 beats, each with one in-refractory edge
        do_reset();
        for (int k = 0; k < 260; k++) begin
            int b;
            b = 10 + 40 * k;
            set_at(b - 1, 1'b1);
            set_at(b + 5, 1'b0);
            set_at(b + 13, 1'b1);
            set_at(b + 19, 1'b0);
            step_to(b + 30);
            if (k == 0) begin
                chk("t5_first_last", last_pulse, b + 7);
                chk("t5_first_rej", reject_count, 1);
            end
            if (k == 253) begin
                chk("t5_beats_254", beat_count, 254);
                chk("t5_rej_254", reject_count, 254);
            end
            if (k == 255) begin
                chk("t5_beats_wrap", beat_count, 0);
                chk("t5_rej_sat", reject_count, 255);
            end
        end
        chk("t5_beats_final", beat_count, 4);
        chk("t5_rej_final", reject_count, 255);
        chk("t5_pulses", pulse_cnt, 260);
        chk("no_double_pulse", dbl_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/heartbeat_detector.md
Name: heartbeat_detector

Overview:
Front-end conditioning stage directly upstream of the pacing timer. It turns the raw, asynchronous, noisy cardiac sense input into a clean one-cycle heartbeat pulse that drives the pacer's heartbeat input.
- Stages: synchronise, debounce, detect the rising edge, then enforce a refractory window so T-waves and bounce are not counted as beats.
- Exposes beat and reject statistics for the io_out debug bits.

Parameters:
SYNC_STAGES, 2, synchroniser flop count (>=2)
DEBOUNCE_CYCLES, 4_800, consecutive stable cycles needed to accept a level change (>=1; 200 us at 24 MHz)
REFRACTORY_CYCLES, 4_800_000, post-beat blanking window in cycles (>=1; 200 ms at 24 MHz)
CNT_W, 32, width of internal debounce, refractory and interval counters

Ports:
clk  in  1  system clock, 24 MHz
rst_n  in  1  asynchronous active-low reset
sense_in  in  1  raw asynchronous heartbeat sense signal (io_in[0])
beat_pulse  out  1  one-cycle pulse per accepted beat; feeds the pacer's heartbeat input
refractory  out  1  high while in the REFRACT state
beat_count  out  8  accepted beats, wraps 255->0
reject_count  out  8  debounced rising edges ignored during refractory; saturates at 255

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - While reset is asserted: sync flops=0, deb_level=0, all counters=0, state=ARMED.
  - All outputs 0 while reset is asserted and in the first cycle after release.
- Reset mid-operation: an in-flight debounce or refractory countdown is abandoned with no pulse emitted.
- Synchroniser: a SYNC_STAGES-deep flop chain. sync_out follows sense_in after SYNC_STAGES edges.
- Debounce:
  - deb_cnt counts consecutive cycles in which sync_out != deb_level.
  - When sync_out == deb_level, deb_cnt clears to 0.
  - When deb_cnt == DEBOUNCE_CYCLES-1 and sync_out still differs, deb_level toggles and deb_cnt clears.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no deb_level change.
- Edge detect: deb_rise is asserted for one cycle when deb_level goes 0->1 (registered previous value).
- State machine:
  - ARMED: on deb_rise, register beat_pulse=1 for one cycle, increment beat_count, load ref_cnt=REFRACTORY_CYCLES-1, go to REFRACT.
  - REFRACT: refractory=1 and ref_cnt decrements each cycle.
    - On deb_rise, increment reject_count (saturating); no pulse is emitted.
    - When ref_cnt==0: go to WAIT_LOW if deb_level==1, otherwise ARMED.
    - If ref_cnt==0 and deb_rise occur in the same cycle, the edge is rejected and counted.
  - WAIT_LOW: go to ARMED when deb_level==0. This prevents a level held high through refractory from re-triggering.
- Latency: a clean rising edge of sense_in, first sampled at edge N, produces beat_pulse high during cycle N+SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Timing: consecutive beat_pulses are at least REFRACTORY_CYCLES+1 cycles apart.
- beat_pulse is never high for two consecutive cycles.

Optional Feature:
Macro: HB_RATE_MEASURE_EN.
- When defined, the block adds:
  - interval_cycles (out, CNT_W): the cycle count between the two most recent accepted beats, saturating at all-ones. It is updated on the cycle beat_pulse is asserted.
  - interval_valid (out, 1): pulses with beat_pulse from the second accepted beat after reset onward.
  - The free-running interval counter restarts at 1 on each accepted beat.
- When not defined, neither port exists and no interval logic is instantiated.

Decomposition:
- Package heartbeat_pkg holds:
  - state enum hb_state_t {HB_ARMED, HB_REFRACT, HB_WAIT_LOW} (2 bits);
  - default cycle constants for 24 MHz (DEBOUNCE, REFRACTORY);
  - the saturating-increment helper function.
- Sub-module hb_sync_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W) outputs deb_level and deb_rise. The top level holds the FSM, counters and optional rate logic.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REFRACTORY_CYCLES=20.
1. Reset, then sense_in rises at edge 10 and stays high 30 cycles -> beat_pulse high only in cycle 17; beat_count=1; refractory high cycles 18-37.
2. 3-cycle high glitch on sense_in while ARMED -> no beat_pulse; beat_count=0; deb_level stays 0.
3. Beat, then sense_in drops and a second clean rise is debounced 10 cycles later (inside refractory) -> no pulse; reject_count=1; after refractory the FSM returns to ARMED and the next clean rise pulses.
4. sense_in held high through the whole refractory window -> FSM enters WAIT_LOW with no extra pulse. Low for 4+ cycles, then high again -> exactly one new pulse.
5. 260 clean beats spaced 40 cycles apart -> beat_count wraps to 4. Injected in-refractory edges -> reject_count saturates at 255, never wraps.
6. rst_n asserted mid-refractory -> all outputs 0 immediately (async). With HB_RATE_MEASURE_EN and beats 40 cycles apart -> interval_cycles=40 and interval_valid starting from the second beat.
